// File: rtl/req_pend_pkg.sv
// Shared types and the priority helper for the request-capture stage.
// Bit 3 has the highest priority, matching the downstream 4-bit encoder.
package req_pend_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;

    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t prio_idx(input req_vec_t vec);
        idx_t idx;
        casez (vec)
            4'b1???: idx = 2'd3;
            4'b01??: idx = 2'd2;
            4'b001?: idx = 2'd1;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/req_pend_ctrl_sync.sv
// Multi-stage flop synchronizer with asynchronous active-high reset.
// SYNC = 0 is a plain wire for inputs that are already clock-synchronous.
module req_sync #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SYNC  = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (SYNC == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign q_o = d_i;
    end else begin : g_sync
        logic [WIDTH-1:0] stage_q [SYNC];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < SYNC; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < SYNC; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[SYNC-1];
    end

endmodule

// File: rtl/req_pend_ctrl.sv
// Request capture: sticky pending bits, masked select for the encoder and
// a valid/ready offer of the highest-priority pending index.
module req_pend_ctrl
    import req_pend_pkg::*;
#(
    parameter bit          EDGE = 1'b1,
    parameter int unsigned SYNC = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    output logic [N_REQ-1:0] sel_o,
    output logic             out_valid_o,
    output logic [IDX_W-1:0] out_idx_o,
    input  logic             out_ready_i,
    output logic [N_REQ-1:0] ovf_o,
    input  logic             ovf_clr_i
);

    req_vec_t req_s, req_d_q;
    req_vec_t pend_q, pend_d;
    req_vec_t ovf_q, ovf_d;
    req_vec_t evt, clr, cand;
    logic     out_valid_q, out_valid_d, acc;
    idx_t     out_idx_q, out_idx_d;

    req_sync #(
        .WIDTH(N_REQ),
        .SYNC (SYNC)
    ) u_req_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (req_i),
        .q_o  (req_s)
    );

    always_comb begin
        evt = EDGE ? (req_s & ~req_d_q) : req_s;
        acc = out_valid_q & out_ready_i;
        clr = '0;
        if (acc) clr[out_idx_q] = 1'b1;

        // New events win over the clear of the accepted bit so none are lost.
        pend_d = (pend_q & ~clr) | evt;
        ovf_d  = (ovf_clr_i ? '0 : ovf_q) | (evt & pend_q & ~clr);

        cand        = pend_q & mask_i & ~clr;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        // A stalled offer is held even if priorities or mask change meanwhile.
        if (!out_valid_q || acc) begin
            out_valid_d = |cand;
            out_idx_d   = prio_idx(cand);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_d_q     <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
        end else begin
            req_d_q     <= req_s;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
        end
    end

    assign sel_o       = pend_q & mask_i;
    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign ovf_o       = ovf_q;

endmodule
